banner_sequencer: RTL and testbench
===================================

BANNER_SEQUENCER -- requirements
Module: banner_sequencer

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixel width used for centring.
REQ-002 Parameter CHAR_W, default 31, horizontal pitch of one glyph in pixels.
REQ-003 Parameter TARGET_Y, default 200, final banner top row.
REQ-004 Parameter SLIDE_STEP, default 8, rows moved per frame while sliding.
REQ-005 Parameter HOLD_FRAMES, default 180, frames held before acknowledge is accepted.
REQ-006 Parameter BLINK_HALF, default 15, frames per blink half-period.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 game_over  input  1  one-cycle pulse requesting a result banner.
REQ-011 result  input  2  00 DRAW, 01 LEFT wins, 10 RIGHT wins, 11 reserved.
REQ-012 ack  input  1  level, player continue request.
REQ-013 word_sel  output  2  registered copy of result, passed to the glyph renderers.
REQ-014 start_x  output  10  banner left column.
REQ-015 start_y  output  10  banner top row.
REQ-016 visible  output  1  banner pixels are enabled.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when the banner is cleared.

Function
REQ-019 The block SHALL implement the states IDLE, SLIDE, HOLD, WAIT_ACK and CLEAR, held in a registered encoding.
REQ-020 In IDLE, a game_over pulse with result != 11 SHALL capture result into word_sel, set start_y=0 and visible=1, and move to SLIDE on the next edge; result=11 SHALL be ignored.
REQ-021 Character count: DRAW=4, LEFT=4, RIGHT=5; start_x SHALL be (H_ACTIVE - count*CHAR_W)>>1 (258, 258, 242 with defaults), computed with 10-bit unsigned truncation toward zero and latched together with word_sel.
REQ-022 In SLIDE, each frame_tick SHALL add SLIDE_STEP to start_y, clamping at TARGET_Y; the tick that reaches TARGET_Y SHALL move to HOLD and clear the frame counter.
REQ-023 In HOLD, each frame_tick SHALL increment an 8-bit frame counter, and visible SHALL toggle whenever a separate blink counter reaches BLINK_HALF-1 (that counter then wraps to 0).
REQ-024 HOLD SHALL move to WAIT_ACK on the frame_tick at which the frame counter equals HOLD_FRAMES-1; ack SHALL be ignored in SLIDE and HOLD.
REQ-025 In WAIT_ACK, blinking SHALL continue; ack=1 on any cycle SHALL move to CLEAR.
REQ-026 CLEAR SHALL last exactly one cycle: visible=0, done=1, then IDLE.
REQ-027 game_over outside IDLE SHALL be ignored; word_sel, start_x and start_y SHALL NOT change outside IDLE.
REQ-028 frame_tick and game_over arriving in the same cycle in IDLE SHALL start the banner only; the first slide step SHALL occur on the next frame_tick.
REQ-029 busy SHALL be combinationally equal to (state != IDLE); all other outputs SHALL be registered.

Reset
REQ-030 reset=1 SHALL force, on the next edge, state=IDLE, word_sel=00, start_x=0, start_y=0, visible=0, done=0, busy=0 and both counters to 0, overriding all other inputs in any state.
REQ-031 After reset, a banner in progress SHALL NOT resume, and done SHALL NOT pulse.

Verification
REQ-032 game_over with result=00, then 25 frame_ticks -> start_x=258; start_y steps 8,16,...,200; state enters HOLD on the 25th tick.
REQ-033 result=10 -> start_x=242, word_sel=10; with BLINK_HALF=15, visible toggles on ticks 15, 30 and 45 of HOLD.
REQ-034 ack held high from the start of SLIDE -> no exit before WAIT_ACK; CLEAR occurs one cycle after entering WAIT_ACK; done pulses for exactly 1 cycle; busy=0 afterwards.
REQ-035 game_over with result=11 in IDLE, and game_over during HOLD -> no state or output change.
REQ-036 reset asserted mid-SLIDE at start_y=96 -> all outputs zero on the next edge; done stays 0.
REQ-037 game_over and frame_tick in the same cycle -> start_y=0 after that edge and 8 after the next frame_tick.

Source files
------------

// File: rtl/banner_if.sv
// Handshake bundle between the game logic and the result-banner sequencer.
// The game logic drives frame/result/ack; the sequencer returns placement and visibility.
interface banner_if;
  logic       frame_tick;
  logic       game_over;
  logic [1:0] result;
  logic       ack;
  logic [1:0] word_sel;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic       visible;
  logic       busy;
  logic       done;

  modport master (
    output frame_tick, game_over, result, ack,
    input  word_sel, start_x, start_y, visible, busy, done
  );

  modport slave (
    input  frame_tick, game_over, result, ack,
    output word_sel, start_x, start_y, visible, busy, done
  );
endinterface

// File: rtl/banner_sequencer.sv
// Result banner sequencer: slides a centred word down to its rest row, blinks it,
// waits for the player to acknowledge, then clears it with a one-cycle done pulse.
module banner_sequencer #(
  parameter int H_ACTIVE    = 640,
  parameter int CHAR_W      = 31,
  parameter int TARGET_Y    = 200,
  parameter int SLIDE_STEP  = 8,
  parameter int HOLD_FRAMES = 180,
  parameter int BLINK_HALF  = 15
) (
  input  logic     clk,
  input  logic     reset,
  banner_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SLIDE    = 3'd1,
    HOLD     = 3'd2,
    WAIT_ACK = 3'd3,
    CLEAR    = 3'd4
  } state_t;

  localparam logic [9:0]  TARGET_Y10 = 10'(TARGET_Y);
  localparam logic [10:0] STEP11     = 11'(SLIDE_STEP);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_HALF - 1);

  state_t      state_q, state_d;
  logic [1:0]  word_sel_q, word_sel_d;
  logic [9:0]  start_x_q, start_x_d;
  logic [9:0]  start_y_q, start_y_d;
  logic        visible_q, visible_d;
  logic        done_q, done_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic [10:0] y_sum;

  // DRAW and LEFT are four glyphs wide, RIGHT is five; code 11 never reaches here.
  function automatic logic [9:0] calc_start_x(input logic [1:0] r);
    logic [31:0] chars;
    logic [31:0] diff;
    chars = (r == 2'b10) ? 32'd5 : 32'd4;
    diff  = 32'(H_ACTIVE) - chars * 32'(CHAR_W);
    return 10'(diff >> 1);
  endfunction

  assign y_sum = {1'b0, start_y_q} + STEP11;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_sel_d  = word_sel_q;
    start_x_d   = start_x_q;
    start_y_d   = start_y_q;
    visible_d   = visible_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.game_over && (bus.result != 2'b11)) begin
          word_sel_d  = bus.result;
          start_x_d   = calc_start_x(bus.result);
          start_y_d   = '0;
          visible_d   = 1'b1;
          frame_cnt_d = '0;
          blink_cnt_d = '0;
          state_d     = SLIDE;
        end
      end

      SLIDE: begin
        if (bus.frame_tick) begin
          if (y_sum >= {1'b0, TARGET_Y10}) begin
            start_y_d   = TARGET_Y10;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            state_d     = HOLD;
          end else begin
            start_y_d = y_sum[9:0];
          end
        end
      end

      HOLD: begin
        if (bus.frame_tick) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            visible_d   = ~visible_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
          if (frame_cnt_q == HOLD_LAST) begin
            state_d = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        if (bus.frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            visible_d   = ~visible_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
        // Acknowledge wins over a blink toggle landing in the same cycle.
        if (bus.ack) begin
          visible_d = 1'b0;
          done_d    = 1'b1;
          state_d   = CLEAR;
        end
      end

      CLEAR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_sel_q  <= '0;
      start_x_q   <= '0;
      start_y_q   <= '0;
      visible_q   <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
    end else begin
      word_sel_q  <= word_sel_d;
      start_x_q   <= start_x_d;
      start_y_q   <= start_y_d;
      visible_q   <= visible_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign bus.word_sel = word_sel_q;
  assign bus.start_x  = start_x_q;
  assign bus.start_y  = start_y_q;
  assign bus.visible  = visible_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_banner_sequencer.sv
// Bench for banner_sequencer: entry vector table, directed multi-cycle sequences,
// then random traffic compared against a tick-counting behavioural model.
module tb_banner_sequencer;
  localparam int H_ACTIVE    = 640;
  localparam int CHAR_W      = 31;
  localparam int TARGET_Y    = 200;
  localparam int SLIDE_STEP  = 8;
  localparam int HOLD_FRAMES = 180;
  localparam int BLINK_HALF  = 15;

  logic clk = 1'b0;
  logic reset;
  banner_if bus();

  banner_sequencer #(
    .H_ACTIVE(H_ACTIVE), .CHAR_W(CHAR_W), .TARGET_Y(TARGET_Y),
    .SLIDE_STEP(SLIDE_STEP), .HOLD_FRAMES(HOLD_FRAMES), .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: position and blink phase derived from tick counts.
  typedef enum int {M_IDLE, M_SLIDE, M_HOLD, M_WAIT, M_CLEAR} mphase_t;
  mphase_t m_phase = M_IDLE;
  int m_slide_ticks, m_hold_ticks, m_post_ticks;
  int m_word, m_x, m_y;
  bit m_vis, m_done;

  function automatic int banner_x(int r);
    int chars;
    chars = (r == 2) ? 5 : 4;
    return (H_ACTIVE - chars * CHAR_W) / 2;
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_phase = M_IDLE; m_word = 0; m_x = 0; m_y = 0; m_vis = 1'b0;
      m_slide_ticks = 0; m_hold_ticks = 0; m_post_ticks = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (bus.game_over && bus.result != 2'b11) begin
          m_word = int'(bus.result); m_x = banner_x(m_word); m_y = 0;
          m_vis = 1'b1; m_slide_ticks = 0; m_phase = M_SLIDE;
        end
        M_SLIDE: if (bus.frame_tick) begin
          m_slide_ticks++;
          m_y = (m_slide_ticks * SLIDE_STEP < TARGET_Y) ? m_slide_ticks * SLIDE_STEP : TARGET_Y;
          if (m_y == TARGET_Y) begin
            m_phase = M_HOLD; m_hold_ticks = 0; m_post_ticks = 0;
          end
        end
        M_HOLD: if (bus.frame_tick) begin
          m_hold_ticks++; m_post_ticks++;
          m_vis = ((m_post_ticks / BLINK_HALF) % 2) == 0;
          if (m_hold_ticks == HOLD_FRAMES) m_phase = M_WAIT;
        end
        M_WAIT: begin
          if (bus.frame_tick) begin
            m_post_ticks++;
            m_vis = ((m_post_ticks / BLINK_HALF) % 2) == 0;
          end
          if (bus.ack) begin
            m_vis = 1'b0; m_done = 1'b1; m_phase = M_CLEAR;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit go, input logic [1:0] res, input bit tick, input bit ak, input bit rst);
    bus.game_over  = go;
    bus.result     = res;
    bus.frame_tick = tick;
    bus.ack        = ak;
    reset          = rst;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    chk("m_word_sel", 32'(bus.word_sel), m_word);
    chk("m_start_x",  32'(bus.start_x),  m_x);
    chk("m_start_y",  32'(bus.start_y),  m_y);
    chk("m_visible",  32'(bus.visible),  32'(m_vis));
    chk("m_done",     32'(bus.done),     32'(m_done));
    chk("m_busy",     32'(bus.busy),     32'(m_phase != M_IDLE));
  endtask

  typedef struct {
    bit         go;
    logic [1:0] res;
    bit         tick;
    int         exp_busy;
    int         exp_word;
    int         exp_x;
    int         exp_y;
    int         exp_vis;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 2'd0, 1'b0, 1, 0, 258, 0, 1};
    vecs[1] = '{1'b1, 2'd1, 1'b0, 1, 1, 258, 0, 1};
    vecs[2] = '{1'b1, 2'd2, 1'b0, 1, 2, 242, 0, 1};
    vecs[3] = '{1'b1, 2'd3, 1'b0, 0, 0, 0,   0, 0};
    vecs[4] = '{1'b0, 2'd2, 1'b1, 0, 0, 0,   0, 0};
    vecs[5] = '{1'b1, 2'd0, 1'b1, 1, 0, 258, 0, 1};

    bus.game_over = 1'b0; bus.result = 2'b00; bus.frame_tick = 1'b0; bus.ack = 1'b0;
    reset = 1'b1;

    // Reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_word_sel", 32'(bus.word_sel), 0);
    chk("rst_start_x",  32'(bus.start_x),  0);
    chk("rst_start_y",  32'(bus.start_y),  0);
    chk("rst_visible",  32'(bus.visible),  0);
    chk("rst_done",     32'(bus.done),     0);
    chk("rst_busy",     32'(bus.busy),     0);

    // Entry vectors from IDLE
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(vecs[i].go, vecs[i].res, vecs[i].tick, 0, 0);
      chk($sformatf("vec%0d_busy", i),     32'(bus.busy),     vecs[i].exp_busy);
      chk($sformatf("vec%0d_word_sel", i), 32'(bus.word_sel), vecs[i].exp_word);
      chk($sformatf("vec%0d_start_x", i),  32'(bus.start_x),  vecs[i].exp_x);
      chk($sformatf("vec%0d_start_y", i),  32'(bus.start_y),  vecs[i].exp_y);
      chk($sformatf("vec%0d_visible", i),  32'(bus.visible),  vecs[i].exp_vis);
      chk($sformatf("vec%0d_done", i),     32'(bus.done),     0);
    end
    // Banner started with a coincident tick: first slide step only on the next tick
    cyc(0, 0, 1, 0, 0);
    chk("same_cycle_next_y", 32'(bus.start_y), 8);

    // DRAW slide: 8,16,...,200 over 25 ticks
    cyc(0, 0, 0, 0, 1);
    cyc(1, 2'd0, 0, 0, 0);
    for (int k = 1; k <= 25; k++) begin
      cyc(0, 0, 1, 0, 0);
      chk($sformatf("slide_y_t%0d", k), 32'(bus.start_y), (k * 8 < 200) ? k * 8 : 200);
      cyc(0, 0, 0, 0, 0);
    end
    chk("slide_start_x", 32'(bus.start_x), 258);
    chk("slide_busy",    32'(bus.busy),    1);

    // RIGHT banner blink toggles at HOLD ticks 15, 30, 45
    cyc(0, 0, 0, 0, 1);
    cyc(1, 2'd2, 0, 0, 0);
    chk("right_start_x",  32'(bus.start_x),  242);
    chk("right_word_sel", 32'(bus.word_sel), 2);
    for (int k = 1; k <= 25; k++) cyc(0, 0, 1, 0, 0);
    for (int h = 1; h <= 45; h++) begin
      cyc(0, 0, 1, 0, 0);
      if (h == 14 || h == 15 || h == 29 || h == 30 || h == 44 || h == 45)
        chk($sformatf("blink_h%0d", h), 32'(bus.visible),
            (h == 15 || h == 29 || h == 45) ? 0 : 1);
    end
    // game_over during HOLD is ignored
    cyc(1, 2'd1, 0, 0, 0);
    chk("hold_go_word_sel", 32'(bus.word_sel), 2);
    chk("hold_go_start_x",  32'(bus.start_x),  242);
    chk("hold_go_start_y",  32'(bus.start_y),  200);
    chk("hold_go_busy",     32'(bus.busy),     1);

    // ack held from the start of SLIDE
    cyc(0, 0, 0, 0, 1);
    cyc(1, 2'd0, 0, 1, 0);
    for (int i = 1; i <= 25 + HOLD_FRAMES; i++) begin
      cyc(0, 0, 1, 1, 0);
      chk($sformatf("ack_early_done_t%0d", i), 32'(bus.done), 0);
      chk($sformatf("ack_early_busy_t%0d", i), 32'(bus.busy), 1);
      if (i < 25 + HOLD_FRAMES) cyc(0, 0, 0, 1, 0);
    end
    cyc(0, 0, 0, 1, 0);
    chk("clear_done",    32'(bus.done),    1);
    chk("clear_visible", 32'(bus.visible), 0);
    chk("clear_busy",    32'(bus.busy),    1);
    cyc(0, 0, 0, 1, 0);
    chk("after_clear_done", 32'(bus.done), 0);
    chk("after_clear_busy", 32'(bus.busy), 0);
    cyc(0, 0, 0, 0, 0);
    chk("after_clear_done2", 32'(bus.done), 0);

    // Reset mid-slide at start_y=96
    cyc(0, 0, 0, 0, 1);
    cyc(1, 2'd1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) cyc(0, 0, 1, 0, 0);
    chk("mid_slide_y", 32'(bus.start_y), 96);
    cyc(1, 2'd2, 1, 1, 1);
    chk("midrst_word_sel", 32'(bus.word_sel), 0);
    chk("midrst_start_x",  32'(bus.start_x),  0);
    chk("midrst_start_y",  32'(bus.start_y),  0);
    chk("midrst_visible",  32'(bus.visible),  0);
    chk("midrst_busy",     32'(bus.busy),     0);
    chk("midrst_done",     32'(bus.done),     0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 1, 0);
      chk("post_rst_done",    32'(bus.done),    0);
      chk("post_rst_busy",    32'(bus.busy),    0);
      chk("post_rst_start_y", 32'(bus.start_y), 0);
    end

    // Random traffic against the model
    cyc(0, 0, 0, 0, 1);
    for (int n = 0; n < 9000; n++) begin
      cyc(($urandom % 16) == 0, 2'($urandom % 4), ($urandom % 2) == 0,
          ($urandom % 12) == 0, ($urandom % 700) == 0);
      chk_model();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
